lsu_wide: RTL and testbench

- Parametrised load/store unit between the integer pipeline and a Wishbone B.4 pipelined master port.
- Splits one XLEN-bit register access (byte/hword/word/dword) into as many BUS_W-bit beats as needed.
- Adds signed/unsigned load extension, misalignment rejection, bus-error termination and a no-memory pass-through path.
- Sits in the memory stage, after the ALU and before register writeback.

---
 rtl/lsu_pkg.sv | 40 ++++
 rtl/lsu_lane_align.sv | 72 +++++++
 rtl/lsu_wide.sv | 188 ++++++++++++++++++
 tb/tb_lsu_wide.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the wide load/store unit.
//   - access size encodings and FSM state type
//   - size_bytes   : access size in bytes (1,2,4,8)
//   - beat_count   : number of bus beats an access needs on a given bus
//   - is_misaligned: alignment check, including dword on a 32-bit core
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    // Wide enough for up to 8 beats (64-bit data on an 8-bit bus).
    localparam int CNT_W = 4;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } lsu_state_t;

    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        return 4'd1 << size;
    endfunction

    // lane_bits = log2(bus bytes). Accesses no wider than the bus take one beat.
    function automatic logic [CNT_W-1:0] beat_count(input logic [1:0] size, input int lane_bits);
        if (int'(size) > lane_bits)
            return CNT_W'(1) << (int'(size) - lane_bits);
        return CNT_W'(1);
    endfunction

    // A dword access has no meaning on a 32-bit core and is rejected as misaligned.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] addr_lo,
                                           input logic xlen64);
        logic [2:0] mask;
        mask = 3'((4'd1 << size) - 4'd1);
        return ((addr_lo & mask) != 3'd0) || ((size == SZ_D) && !xlen64);
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational data steering between register width and bus lanes.
// Ports:
//   i_size, i_signed : latched access size and load signedness
//   i_off            : byte offset of the access inside a bus word
//   i_beat           : index of the beat currently being issued
//   i_sdat           : latched store data (register width)
//   o_wdat, o_sel    : store beat data and lane select (ungated)
//   i_ldat           : assembled raw load data (beat k in slot k)
//   o_ldat           : lane-extracted, zero/sign-extended load result
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int BUS_W = 16,
    parameter int BB    = BUS_W / 8,
    parameter int LB    = $clog2(BUS_W / 8)
) (
    input  logic [1:0]       i_size,
    input  logic             i_signed,
    input  logic [LB-1:0]    i_off,
    input  logic [CNT_W-1:0] i_beat,
    input  logic [XLEN-1:0]  i_sdat,
    output logic [BUS_W-1:0] o_wdat,
    output logic [BB-1:0]    o_sel,
    input  logic [XLEN-1:0]  i_ldat,
    output logic [XLEN-1:0]  o_ldat
);

    logic [3:0]       w_nb;
    logic             w_narrow;
    logic [2:0]       w_nbm1;
    logic [7:0]       w_lanes;
    logic [BUS_W-1:0] w_rep;
    logic [BUS_W-1:0] w_slice;
    logic [XLEN-1:0]  w_shift;
    logic [6:0]       w_nbits;
    logic             w_sign;

    assign w_nb     = size_bytes(i_size);
    assign w_narrow = int'(w_nb) < BB;
    assign w_nbm1   = 3'(w_nb - 4'd1);
    assign w_lanes  = 8'((9'd1 << w_nb) - 9'd1);

    // Narrow store: bus byte lane gi carries store byte (gi mod NB), so the
    // addressed lanes always see the right bytes whatever the offset.
    genvar gi;
    for (gi = 0; gi < BB; gi++) begin : g_rep
        assign w_rep[gi*8 +: 8] = i_sdat[{3'(gi) & w_nbm1, 3'b000} +: 8];
    end

    assign w_slice = BUS_W'(i_sdat >> (int'(i_beat) * BUS_W));
    assign o_wdat  = w_narrow ? w_rep : w_slice;
    assign o_sel   = w_narrow ? (BB'(w_lanes) << i_off) : {BB{1'b1}};

    // Aligned wide accesses have i_off = 0, so one shift serves both cases.
    assign w_shift = i_ldat >> {i_off, 3'b000};
    assign w_nbits = 7'(w_nb) << 3;

    always_comb begin
        case (i_size)
            SZ_B:    w_sign = w_shift[7];
            SZ_H:    w_sign = w_shift[15];
            SZ_W:    w_sign = w_shift[31];
            default: w_sign = w_shift[XLEN-1];
        endcase
    end

    for (gi = 0; gi < XLEN; gi++) begin : g_ext
        assign o_ldat[gi] = (gi < int'(w_nbits)) ? w_shift[gi] : (i_signed & w_sign);
    end

endmodule

// File: rtl/lsu_wide.sv
// Load/store unit: splits one register-width access into Wishbone B.4
// pipelined beats, assembles and extends load data, rejects misaligned
// requests, terminates on bus error and forwards non-memory results.
// Ports:
//   clk_i, reset_i               : clock, synchronous active-high reset
//   req_i, nomem_i, we_i, size_i : request, pass-through, store, size
//   signed_i, addr_i, dat_i      : load signedness, byte address, store data
//   busy_o, rwe_o, dat_o         : busy, completion pulse, load result
//   misal_o, buserr_o            : misalignment / bus-error pulses
//   wbm*_o / wbm*_i              : Wishbone pipelined master port
module lsu_wide
    import lsu_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int BUS_W = 16,
    parameter int AW    = 64
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               req_i,
    input  logic               nomem_i,
    input  logic               we_i,
    input  logic [1:0]         size_i,
    input  logic               signed_i,
    input  logic [AW-1:0]      addr_i,
    input  logic [XLEN-1:0]    dat_i,
    output logic               busy_o,
    output logic               rwe_o,
    output logic [XLEN-1:0]    dat_o,
    output logic               misal_o,
    output logic               buserr_o,
    output logic [AW-1:0]      wbmadr_o,
    output logic [BUS_W-1:0]   wbmdat_o,
    output logic               wbmwe_o,
    output logic               wbmstb_o,
    output logic               wbmcyc_o,
    output logic [BUS_W/8-1:0] wbmsel_o,
    input  logic               wbmstall_i,
    input  logic               wbmack_i,
    input  logic               wbmerr_i,
    input  logic [BUS_W-1:0]   wbmdat_i
);

    localparam int BB   = BUS_W / 8;
    localparam int LB   = $clog2(BB);
    localparam int MAXB = XLEN / BUS_W;

    lsu_state_t       r_state;
    logic [AW-1:0]    r_addr;
    logic [1:0]       r_size;
    logic             r_we;
    logic             r_signed;
    logic [XLEN-1:0]  r_sdat;
    logic [XLEN-1:0]  r_buf;
    logic [XLEN-1:0]  r_dat;
    logic [CNT_W-1:0] r_beats;
    logic [CNT_W-1:0] r_issued;
    logic [CNT_W-1:0] r_acked;
    logic             r_rwe;
    logic             r_misal;
    logic             r_buserr;

    logic             w_active;
    logic             w_misal;
    logic             w_stb;
    logic             w_issue;
    logic             w_ack;
    logic             w_last;
    logic             w_err;
    logic [AW-1:0]    w_base;
    logic [XLEN-1:0]  w_buf_next;
    logic [BUS_W-1:0] w_wdat;
    logic [BB-1:0]    w_sel;
    logic [XLEN-1:0]  w_ld;

    assign w_active = (r_state == S_ACTIVE);
    assign w_misal  = is_misaligned(size_i, addr_i[2:0], XLEN == 64);
    assign w_stb    = w_active && (r_issued < r_beats);
    assign w_issue  = w_stb && !wbmstall_i;
    // Acks with nothing outstanding are stray and ignored.
    assign w_ack    = w_active && wbmack_i && (r_acked != r_issued);
    assign w_last   = w_ack && (r_acked == r_beats - CNT_W'(1));
    assign w_err    = w_active && wbmerr_i;

    // The issue counter only moves on an unstalled strobe, so the address holds.
    assign w_base   = {r_addr[AW-1:LB], {LB{1'b0}}};
    assign wbmadr_o = w_base + (AW'(r_issued) << LB);

    // Raw load buffer with the current acked beat merged into its slot, so
    // the final beat is visible to the extender in the completing cycle.
    genvar gi;
    for (gi = 0; gi < MAXB; gi++) begin : g_slot
        assign w_buf_next[gi*BUS_W +: BUS_W] = (r_acked == CNT_W'(gi)) ? wbmdat_i
                                                                       : r_buf[gi*BUS_W +: BUS_W];
    end

    lsu_lane_align #(
        .XLEN  (XLEN),
        .BUS_W (BUS_W)
    ) u_align (
        .i_size   (r_size),
        .i_signed (r_signed),
        .i_off    (r_addr[LB-1:0]),
        .i_beat   (r_issued),
        .i_sdat   (r_sdat),
        .o_wdat   (w_wdat),
        .o_sel    (w_sel),
        .i_ldat   (w_buf_next),
        .o_ldat   (w_ld)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_size   <= SZ_B;
            r_we     <= 1'b0;
            r_signed <= 1'b0;
            r_sdat   <= '0;
            r_buf    <= '0;
            r_dat    <= '0;
            r_beats  <= '0;
            r_issued <= '0;
            r_acked  <= '0;
            r_rwe    <= 1'b0;
            r_misal  <= 1'b0;
            r_buserr <= 1'b0;
        end else begin
            r_rwe    <= 1'b0;
            r_misal  <= 1'b0;
            r_buserr <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (nomem_i) begin
                        r_dat <= XLEN'(addr_i);
                        r_rwe <= 1'b1;
                    end else if (req_i) begin
                        if (w_misal) begin
                            r_misal <= 1'b1;
                        end else begin
                            r_state  <= S_ACTIVE;
                            r_addr   <= addr_i;
                            r_size   <= size_i;
                            r_we     <= we_i;
                            r_signed <= signed_i;
                            r_sdat   <= dat_i;
                            r_buf    <= '0;
                            r_beats  <= beat_count(size_i, LB);
                            r_issued <= '0;
                            r_acked  <= '0;
                        end
                    end
                end
                S_ACTIVE: begin
                    if (w_issue)
                        r_issued <= r_issued + CNT_W'(1);
                    // Error wins over a simultaneous ack; remaining beats are dropped.
                    if (w_err) begin
                        r_state  <= S_IDLE;
                        r_buserr <= 1'b1;
                    end else if (w_ack) begin
                        r_buf   <= w_buf_next;
                        r_acked <= r_acked + CNT_W'(1);
                        if (w_last) begin
                            r_state <= S_IDLE;
                            r_rwe   <= 1'b1;
                            if (!r_we)
                                r_dat <= w_ld;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy_o   = w_active;
    assign wbmcyc_o = w_active;
    assign wbmstb_o = w_stb;
    assign wbmwe_o  = w_stb & r_we;
    assign wbmsel_o = w_stb ? w_sel : '0;
    assign wbmdat_o = w_wdat;
    assign rwe_o    = r_rwe;
    assign dat_o    = r_dat;
    assign misal_o  = r_misal;
    assign buserr_o = r_buserr;

endmodule

// File: tb/tb_lsu_wide.sv
// Directed bench for lsu_wide: a 16-bit-bus instance for the main scenarios
// and a 32-bit-bus instance for the misalignment scenario.
module tb_lsu_wide;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_i = 1'b1;
    // 16-bit bus instance
    logic        req = 0, nomem = 0, we = 0, sgn = 0;
    logic [1:0]  size = 0;
    logic [63:0] addr = 0, wdat = 0;
    logic        busy, rwe, misal, buserr, mwe, stb, cyc;
    logic [63:0] dat, madr;
    logic [15:0] mdat_o;
    logic [1:0]  sel;
    logic        stall = 0, ack = 0, err = 0;
    logic [15:0] mdat_i = 0;
    // 32-bit bus instance
    logic        req32 = 0, nomem32 = 0;
    logic [1:0]  size32 = 0;
    logic [63:0] addr32 = 0;
    logic        busy32, rwe32, misal32, buserr32, mwe32, stb32, cyc32;
    logic [63:0] dat32, madr32;
    logic [31:0] mdat32_o;
    logic [3:0]  sel32;

    int n_checks = 0;
    int n_fail   = 0;

    lsu_wide #(.XLEN(64), .BUS_W(16), .AW(64)) u_dut (
        .clk_i(clk), .reset_i(reset_i), .req_i(req), .nomem_i(nomem), .we_i(we),
        .size_i(size), .signed_i(sgn), .addr_i(addr), .dat_i(wdat),
        .busy_o(busy), .rwe_o(rwe), .dat_o(dat), .misal_o(misal), .buserr_o(buserr),
        .wbmadr_o(madr), .wbmdat_o(mdat_o), .wbmwe_o(mwe), .wbmstb_o(stb), .wbmcyc_o(cyc),
        .wbmsel_o(sel), .wbmstall_i(stall), .wbmack_i(ack), .wbmerr_i(err), .wbmdat_i(mdat_i)
    );

    lsu_wide #(.XLEN(64), .BUS_W(32), .AW(64)) u_dut32 (
        .clk_i(clk), .reset_i(reset_i), .req_i(req32), .nomem_i(nomem32), .we_i(1'b0),
        .size_i(size32), .signed_i(1'b0), .addr_i(addr32), .dat_i(64'd0),
        .busy_o(busy32), .rwe_o(rwe32), .dat_o(dat32), .misal_o(misal32), .buserr_o(buserr32),
        .wbmadr_o(madr32), .wbmdat_o(mdat32_o), .wbmwe_o(mwe32), .wbmstb_o(stb32), .wbmcyc_o(cyc32),
        .wbmsel_o(sel32), .wbmstall_i(1'b0), .wbmack_i(1'b0), .wbmerr_i(1'b0), .wbmdat_i(32'd0)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset_i = 1'b1;
        repeat (3) tick;
        n_checks++; if ({busy, rwe, misal, buserr, cyc, stb, mwe} !== 7'd0) begin n_fail++; $display("FAIL reset_flags: got %b want 0", {busy, rwe, misal, buserr, cyc, stb, mwe}); end
        n_checks++; if (dat !== 64'd0) begin n_fail++; $display("FAIL reset_dat: got %h want 0", dat); end
        n_checks++; if (sel !== 2'b00) begin n_fail++; $display("FAIL reset_sel: got %b want 00", sel); end
        n_checks++; if ({busy32, cyc32, rwe32} !== 3'd0) begin n_fail++; $display("FAIL reset_dut32: got %b want 0", {busy32, cyc32, rwe32}); end
        reset_i = 1'b0;
        tick;
        $display("test_reset done");
    endtask

    task automatic test_byte_load_signed;
        req = 1; we = 0; size = 2'b00; sgn = 1; addr = 64'h1003;
        tick; req = 0;
        n_checks++; if (stb !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL bl_stb: got stb=%b busy=%b want 1 1", stb, busy); end
        n_checks++; if (sel !== 2'b10) begin n_fail++; $display("FAIL bl_sel: got %b want 10", sel); end
        n_checks++; if (madr !== 64'h1002) begin n_fail++; $display("FAIL bl_adr: got %h want 1002", madr); end
        n_checks++; if (mwe !== 1'b0) begin n_fail++; $display("FAIL bl_we: got %b want 0", mwe); end
        tick;
        ack = 1; mdat_i = 16'h80AA;
        n_checks++; if (stb !== 1'b0 || cyc !== 1'b1) begin n_fail++; $display("FAIL bl_after_issue: got stb=%b cyc=%b want 0 1", stb, cyc); end
        tick; ack = 0;
        n_checks++; if (rwe !== 1'b1 || cyc !== 1'b0) begin n_fail++; $display("FAIL bl_done: got rwe=%b cyc=%b want 1 0", rwe, cyc); end
        n_checks++; if (dat !== 64'hFFFF_FFFF_FFFF_FF80) begin n_fail++; $display("FAIL bl_dat: got %h want ffffffffffffff80", dat); end
        tick;
        n_checks++; if (rwe !== 1'b0) begin n_fail++; $display("FAIL bl_rwe_pulse: got %b want 0", rwe); end
        $display("test_byte_load_signed done dat=%h", dat);
    endtask

    task automatic test_dword_store;
        logic [15:0] exp_d [4];
        logic prev_iss;
        int k, rwe_cyc, n_rwe;
        exp_d[0] = 16'h7788; exp_d[1] = 16'h5566; exp_d[2] = 16'h3344; exp_d[3] = 16'h1122;
        prev_iss = 0; k = 0; rwe_cyc = -1; n_rwe = 0;
        req = 1; we = 1; size = 2'b11; sgn = 0; addr = 64'h2000; wdat = 64'h1122_3344_5566_7788;
        for (int c = 1; c <= 8; c++) begin
            tick; req = 0;
            ack = prev_iss;
            if (stb && k < 4) begin
                n_checks++; if (madr !== 64'h2000 + 64'(2 * k)) begin n_fail++; $display("FAIL ds_adr%0d: got %h want %h", k, madr, 64'h2000 + 64'(2 * k)); end
                n_checks++; if (mdat_o !== exp_d[k]) begin n_fail++; $display("FAIL ds_dat%0d: got %h want %h", k, mdat_o, exp_d[k]); end
                n_checks++; if (sel !== 2'b11 || mwe !== 1'b1) begin n_fail++; $display("FAIL ds_sel_we%0d: got %b %b want 11 1", k, sel, mwe); end
                k++;
            end
            prev_iss = stb && !stall;
            if (rwe) begin n_rwe++; if (rwe_cyc < 0) rwe_cyc = c; end
        end
        ack = 0; we = 0;
        n_checks++; if (k !== 4) begin n_fail++; $display("FAIL ds_beats: got %0d want 4", k); end
        n_checks++; if (rwe_cyc !== 6 || n_rwe !== 1) begin n_fail++; $display("FAIL ds_rwe_timing: got cycle %0d count %0d want cycle 6 count 1", rwe_cyc, n_rwe); end
        n_checks++; if (dat !== 64'hFFFF_FFFF_FFFF_FF80) begin n_fail++; $display("FAIL ds_dat_kept: got %h want ffffffffffffff80", dat); end
        $display("test_dword_store done beats=%0d rwe_cycle=%0d", k, rwe_cyc);
    endtask

    task automatic test_word_stall;
        logic [15:0] vals [2];
        logic prev_iss;
        int k, na, rwe_cyc;
        vals[0] = 16'hAAAA; vals[1] = 16'hBBBB;
        prev_iss = 0; k = 0; na = 0; rwe_cyc = -1;
        req = 1; we = 0; size = 2'b10; sgn = 0; addr = 64'h3004;
        for (int c = 1; c <= 8; c++) begin
            tick; req = 0;
            stall = (c <= 2);
            ack = prev_iss;
            if (prev_iss && na < 2) begin mdat_i = vals[na]; na++; end
            if (stb) begin
                n_checks++; if (madr !== 64'h3004 + 64'(2 * k)) begin n_fail++; $display("FAIL ws_adr c%0d: got %h want %h", c, madr, 64'h3004 + 64'(2 * k)); end
            end
            if (stb && !stall) k++;
            prev_iss = stb && !stall;
            if (rwe && rwe_cyc < 0) begin
                rwe_cyc = c;
                n_checks++; if (dat !== 64'h0000_0000_BBBB_AAAA) begin n_fail++; $display("FAIL ws_dat: got %h want 00000000bbbbaaaa", dat); end
            end
        end
        stall = 0; ack = 0;
        n_checks++; if (rwe_cyc !== 6 || k !== 2) begin n_fail++; $display("FAIL ws_timing: got cycle %0d beats %0d want cycle 6 beats 2", rwe_cyc, k); end
        $display("test_word_stall done dat=%h", dat);
    endtask

    task automatic test_misaligned;
        nomem32 = 1; addr32 = 64'h1234;
        tick; nomem32 = 0;
        n_checks++; if (rwe32 !== 1'b1 || dat32 !== 64'h1234) begin n_fail++; $display("FAIL ma_nomem: got rwe=%b dat=%h want 1 1234", rwe32, dat32); end
        req32 = 1; size32 = 2'b01; addr32 = 64'h4001;
        tick; req32 = 0;
        n_checks++; if (misal32 !== 1'b1) begin n_fail++; $display("FAIL ma_pulse: got %b want 1", misal32); end
        n_checks++; if (cyc32 !== 1'b0 || rwe32 !== 1'b0) begin n_fail++; $display("FAIL ma_nobus: got cyc=%b rwe=%b want 0 0", cyc32, rwe32); end
        for (int c = 0; c < 3; c++) begin
            tick;
            n_checks++; if ({cyc32, stb32, busy32, mwe32, misal32, buserr32} !== 6'd0 || sel32 !== 4'd0) begin n_fail++; $display("FAIL ma_idle c%0d: got %b sel=%b want 0", c, {cyc32, stb32, busy32, mwe32, misal32, buserr32}, sel32); end
        end
        n_checks++; if (dat32 !== 64'h1234) begin n_fail++; $display("FAIL ma_dat_kept: got %h want 1234", dat32); end
        n_checks++; if (madr32 !== 64'd0 || mdat32_o !== 32'd0) begin n_fail++; $display("FAIL ma_nolatch: got adr=%h dat=%h want 0 0", madr32, mdat32_o); end
        $display("test_misaligned done");
    endtask

    task automatic test_bus_error;
        int n_rwe;
        n_rwe = 0;
        req = 1; we = 0; size = 2'b11; sgn = 1; addr = 64'h5000;
        for (int c = 1; c <= 7; c++) begin
            tick; req = 0;
            ack = (c == 2 || c == 3); err = (c == 4); mdat_i = 16'hFFFF;
            if (c == 4) begin
                n_checks++; if (stb !== 1'b1 || madr !== 64'h5006) begin n_fail++; $display("FAIL be_beat3: got stb=%b adr=%h want 1 5006", stb, madr); end
            end
            if (c == 5) begin
                n_checks++; if (cyc !== 1'b0 || stb !== 1'b0) begin n_fail++; $display("FAIL be_drop: got cyc=%b stb=%b want 0 0", cyc, stb); end
                n_checks++; if (buserr !== 1'b1) begin n_fail++; $display("FAIL be_pulse: got %b want 1", buserr); end
            end
            if (c == 6) begin
                n_checks++; if (buserr !== 1'b0) begin n_fail++; $display("FAIL be_pulse_end: got %b want 0", buserr); end
            end
            if (rwe) n_rwe++;
        end
        ack = 0; err = 0;
        n_checks++; if (n_rwe !== 0) begin n_fail++; $display("FAIL be_no_rwe: got %0d pulses want 0", n_rwe); end
        n_checks++; if (dat !== 64'h0000_0000_BBBB_AAAA) begin n_fail++; $display("FAIL be_dat_kept: got %h want 00000000bbbbaaaa", dat); end
        $display("test_bus_error done");
    endtask

    task automatic test_back_to_back;
        req = 1; we = 1; size = 2'b00; sgn = 0; addr = 64'h7001; wdat = 64'h0000_0000_0000_00AB;
        tick; req = 0;
        n_checks++; if (madr !== 64'h7000 || sel !== 2'b10) begin n_fail++; $display("FAIL bb_st_adr_sel: got %h %b want 7000 10", madr, sel); end
        n_checks++; if (mdat_o !== 16'hABAB || mwe !== 1'b1) begin n_fail++; $display("FAIL bb_st_dat: got %h we=%b want abab 1", mdat_o, mwe); end
        tick; ack = 1;
        tick; ack = 0;
        n_checks++; if (rwe !== 1'b1 || cyc !== 1'b0) begin n_fail++; $display("FAIL bb_st_done: got rwe=%b cyc=%b want 1 0", rwe, cyc); end
        n_checks++; if (dat !== 64'h0000_0000_BBBB_AAAA) begin n_fail++; $display("FAIL bb_st_dat_kept: got %h want 00000000bbbbaaaa", dat); end
        req = 1; we = 0; size = 2'b01; sgn = 1; addr = 64'h7002;
        tick; req = 0;
        n_checks++; if (stb !== 1'b1 || madr !== 64'h7002 || sel !== 2'b11 || mwe !== 1'b0) begin n_fail++; $display("FAIL bb_ld_issue: got stb=%b adr=%h sel=%b we=%b want 1 7002 11 0", stb, madr, sel, mwe); end
        tick; ack = 1; mdat_i = 16'h8001;
        tick; ack = 0;
        n_checks++; if (rwe !== 1'b1 || dat !== 64'hFFFF_FFFF_FFFF_8001) begin n_fail++; $display("FAIL bb_ld_dat: got rwe=%b dat=%h want 1 ffffffffffff8001", rwe, dat); end
        $display("test_back_to_back done dat=%h", dat);
    endtask

    task automatic test_reset_mid;
        req = 1; we = 1; size = 2'b11; sgn = 0; addr = 64'h6000; wdat = 64'hDEAD_BEEF_0123_4567;
        tick; req = 0;
        tick;
        n_checks++; if (stb !== 1'b1 || madr !== 64'h6002) begin n_fail++; $display("FAIL rm_beat1: got stb=%b adr=%h want 1 6002", stb, madr); end
        reset_i = 1; ack = 1;
        tick; reset_i = 0; ack = 0;
        n_checks++; if ({cyc, stb, rwe, buserr, misal} !== 5'd0) begin n_fail++; $display("FAIL rm_drop: got %b want 0", {cyc, stb, rwe, buserr, misal}); end
        n_checks++; if (dat !== 64'd0) begin n_fail++; $display("FAIL rm_dat: got %h want 0", dat); end
        tick;
        n_checks++; if ({cyc, rwe, buserr} !== 3'd0) begin n_fail++; $display("FAIL rm_quiet: got %b want 0", {cyc, rwe, buserr}); end
        nomem = 1; req = 1; we = 0; size = 2'b00; addr = 64'h55;
        tick; nomem = 0; req = 0;
        n_checks++; if (rwe !== 1'b1 || dat !== 64'h55 || cyc !== 1'b0) begin n_fail++; $display("FAIL rm_nomem: got rwe=%b dat=%h cyc=%b want 1 55 0", rwe, dat, cyc); end
        tick;
        n_checks++; if (rwe !== 1'b0 || cyc !== 1'b0) begin n_fail++; $display("FAIL rm_nomem_after: got rwe=%b cyc=%b want 0 0", rwe, cyc); end
        $display("test_reset_mid done dat=%h", dat);
    endtask

    initial begin
        test_reset;
        test_byte_load_signed;
        test_dword_store;
        test_word_stall;
        test_misaligned;
        test_bus_error;
        test_back_to_back;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
